// File: rtl/ram2_ctrl.sv
// Request/response front end for the ram2 single-port RAM: sequences write, read
// and whole-array clear cycles and owns the tristate control of the shared data bus.
module ram2_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  mem_ena,
    output logic                  mem_wena,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CLR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    bus_drive;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        req_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Clear wins over a simultaneous request, so ready drops with clr_start.
                req_ready = !clr_start;
                if (clr_start) begin
                    state_d = S_CLR;
                    cnt_d   = '0;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = req_we;
                    state_d = req_we ? S_WR : S_RD;
                end
            end
            S_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_RD: begin
                rdata_d     = mem_data;
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_CLR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_ena   = (state_q != S_IDLE);
    assign mem_wena  = (state_q == S_WR) || (state_q == S_CLR);
    assign mem_addr  = (state_q == S_CLR) ? cnt_q : addr_q;
    assign bus_drive = mem_wena;
    assign mem_data  = bus_drive ? ((state_q == S_CLR) ? CLR_VALUE : wdata_q) : 'z;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule
